// File: rtl/player_turn_ctrl_if.sv
// player_turn_ctrl_if
//   Groups the game-side signals of the two-player turn controller.
//   slave  : controller side (buttons, frame/move/game-over in; select/status out)
//   master : environment side (drives buttons and game events, observes status)
//   Signals:
//     btn_next, btn_confirm : raw asynchronous buttons, active-high
//     frame_start           : one-cycle pulse at scan position (0,0)
//     move_done             : one-cycle pulse, active player finished a move
//     game_over             : level from game logic
//     sel[1:0]              : sprite select, 00 none / 01 Rick / 10 Morty
//     active_player         : 0 Rick, 1 Morty
//     fsm_state[1:0]        : 00 IDLE / 01 CHOOSE / 10 PLAY / 11 OVER
//     turn_timeout          : one-cycle pulse on a forced hand-over
interface player_turn_ctrl_if;
   logic       btn_next;
   logic       btn_confirm;
   logic       frame_start;
   logic       move_done;
   logic       game_over;
   logic [1:0] sel;
   logic       active_player;
   logic [1:0] fsm_state;
   logic       turn_timeout;

   modport slave (
      input  btn_next, btn_confirm, frame_start, move_done, game_over,
      output sel, active_player, fsm_state, turn_timeout
   );

   modport master (
      output btn_next, btn_confirm, frame_start, move_done, game_over,
      input  sel, active_player, fsm_state, turn_timeout
   );
endinterface

// File: rtl/player_turn_ctrl.sv
// player_turn_ctrl
//   Debounces the two front-panel buttons and sequences the select / play /
//   game-over flow of the two-player VGA game. The sprite select code is only
//   reloaded on frame_start so a sprite never changes mid-frame.
//   Ports:
//     clk   : pixel/system clock
//     rst_n : synchronous active-low reset
//     bus   : player_turn_ctrl_if.slave (buttons, game events, select/status)
//   Parameters:
//     DEBOUNCE_CYCLES : stable synchronized cycles before a level is accepted (>=2)
//     BLINK_FRAMES    : frames per blink half-period while choosing (>=1)
//     TURN_FRAMES     : frames per turn before a forced hand-over (>=1)
module player_turn_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_FRAMES    = 30,
   parameter int TURN_FRAMES     = 600
) (
   input  logic              clk,
   input  logic              rst_n,
   player_turn_ctrl_if.slave bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int TW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_FRAMES - 1);

   localparam logic [1:0] ST_IDLE   = 2'b00;
   localparam logic [1:0] ST_CHOOSE = 2'b01;
   localparam logic [1:0] ST_PLAY   = 2'b10;
   localparam logic [1:0] ST_OVER   = 2'b11;

   localparam logic [1:0] SEL_NONE  = 2'b00;
   localparam logic [1:0] SEL_RICK  = 2'b01;
   localparam logic [1:0] SEL_MORTY = 2'b10;

   // Button path, bit 0 = next, bit 1 = confirm
   logic [1:0]          raw_s;
   logic [1:0]          sync1_q, sync2_q;
   logic [1:0]          deb_q, deb_d;
   logic [1:0]          deb_dly_q;
   logic [1:0]          press_q, press_d;
   logic [1:0][DW-1:0]  db_cnt_q, db_cnt_d;
   logic                press_next_s, press_confirm_s;

   // Sequencer state
   logic [1:0]          state_q, state_d;
   logic                cand_q, cand_d;
   logic                phase_q, phase_d;
   logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                active_q, active_d;
   logic [TW-1:0]       turn_cnt_q, turn_cnt_d;
   logic                timeout_q, timeout_d;
   logic                turn_end_s;
   logic [1:0]          target_s;
   logic [1:0]          sel_q, sel_d;

   assign raw_s = {bus.btn_confirm, bus.btn_next};

   // Debounce counters: run while the synchronized level disagrees with deb
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] != deb_q[b]) begin
            if (db_cnt_q[b] == DEB_LAST) begin
               deb_d[b]    = sync2_q[b];
               db_cnt_d[b] = {DW{1'b0}};
            end else begin
               db_cnt_d[b] = db_cnt_q[b] + DW'(1'b1);
            end
         end else begin
            db_cnt_d[b] = {DW{1'b0}};
         end
      end
      // Rising edge of the debounced level only; releases are dropped
      press_d = deb_q & ~deb_dly_q;
   end

   // Button synchronizers, debounced levels and registered press pulses
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= 2'b00;
         sync2_q   <= 2'b00;
         deb_q     <= 2'b00;
         deb_dly_q <= 2'b00;
         press_q   <= 2'b00;
         db_cnt_q  <= {(2*DW){1'b0}};
      end else begin
         sync1_q   <= raw_s;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         press_q   <= press_d;
         db_cnt_q  <= db_cnt_d;
      end
   end

   // Confirm wins when both presses land in the same cycle
   assign press_confirm_s = press_q[1];
   assign press_next_s    = press_q[0] & ~press_q[1];

   assign turn_end_s = bus.frame_start & (turn_cnt_q == TURN_LAST);

   // Select/play/game-over sequencer next state
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      phase_d     = phase_q;
      blink_cnt_d = blink_cnt_q;
      active_d    = active_q;
      turn_cnt_d  = turn_cnt_q;
      timeout_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (press_next_s | press_confirm_s) begin
               state_d     = ST_CHOOSE;
               cand_d      = 1'b0;
               phase_d     = 1'b1;
               blink_cnt_d = {BW{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHOOSE: begin
            if (press_confirm_s) begin
               state_d    = ST_PLAY;
               active_d   = cand_q;
               turn_cnt_d = {TW{1'b0}};
            end else if (press_next_s) begin
               // Switching candidate restarts the blink so the new sprite shows at once
               cand_d      = ~cand_q;
               phase_d     = 1'b1;
               blink_cnt_d = {BW{1'b0}};
            end else if (bus.frame_start) begin
               if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = {BW{1'b0}};
                  phase_d     = ~phase_q;
               end else begin
                  blink_cnt_d = blink_cnt_q + BW'(1'b1);
               end
            end else begin
               blink_cnt_d = blink_cnt_q;
            end
         end
         ST_PLAY: begin
            if (bus.game_over) begin
               // Game over freezes the player even if a hand-over coincides
               state_d = ST_OVER;
            end else if (bus.move_done | turn_end_s) begin
               // A coincident move and timeout is a single hand-over, not a timeout
               active_d   = ~active_q;
               turn_cnt_d = {TW{1'b0}};
               timeout_d  = turn_end_s & ~bus.move_done;
            end else if (bus.frame_start) begin
               turn_cnt_d = turn_cnt_q + TW'(1'b1);
            end else begin
               turn_cnt_d = turn_cnt_q;
            end
         end
         ST_OVER: begin
            if (press_confirm_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OVER;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sprite code the current state asks for; sampled into sel only at frame start
   always_comb begin
      target_s = SEL_NONE;
      case (state_q)
         ST_IDLE: begin
            target_s = SEL_NONE;
         end
         ST_CHOOSE: begin
            if (phase_q) begin
               target_s = cand_q ? SEL_MORTY : SEL_RICK;
            end else begin
               target_s = SEL_NONE;
            end
         end
         ST_PLAY, ST_OVER: begin
            target_s = active_q ? SEL_MORTY : SEL_RICK;
         end
         default: begin
            target_s = SEL_NONE;
         end
      endcase
      if (bus.frame_start) begin
         sel_d = target_s;
      end else begin
         sel_d = sel_q;
      end
   end

   // Sequencer and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cand_q      <= 1'b0;
         phase_q     <= 1'b0;
         blink_cnt_q <= {BW{1'b0}};
         active_q    <= 1'b0;
         turn_cnt_q  <= {TW{1'b0}};
         timeout_q   <= 1'b0;
         sel_q       <= SEL_NONE;
      end else begin
         state_q     <= state_d;
         cand_q      <= cand_d;
         phase_q     <= phase_d;
         blink_cnt_q <= blink_cnt_d;
         active_q    <= active_d;
         turn_cnt_q  <= turn_cnt_d;
         timeout_q   <= timeout_d;
         sel_q       <= sel_d;
      end
   end

   assign bus.sel           = sel_q;
   assign bus.active_player = active_q;
   assign bus.fsm_state     = state_q;
   assign bus.turn_timeout  = timeout_q;

endmodule
